pc_fetch_reg: RTL and testbench
===============================

// Module: pc_fetch_reg
// PURPOSE
//  Program-counter register and instruction-fetch sequencer. It sits directly downstream of pc_select_mux:
//  - pc_plus4 drives the mux pc_in; the mux result returns here as next_pc.
//  - The block holds the architectural PC and issues one fetch per instruction over a req/ack imem port.
//  - It presents the fetched word to decode with a valid/ready handshake.
//  - The PC advances only when decode accepts the current instruction.
// PARAMETERS
//  XLEN          32            datapath / address width
//  RESET_VECTOR  32'h0000_0000 PC value loaded by reset
//  TRAP_VECTOR   32'h0000_0100 redirect target on misaligned next_pc (MISALIGN_TRAP_EN only)
// PORTS
//  clk            in   1     rising-edge clock
//  rst            in   1     asynchronous, active-high reset
//  next_pc        in   XLEN  next PC from pc_select_mux result
//  stall          in   1     hazard hold; blocks PC advance
//  imem_req       out  1     fetch request, held until imem_ack
//  imem_addr      out  XLEN  fetch address (= pc)
//  imem_ack       in   1     imem_rdata valid this cycle
//  imem_rdata     in   32    fetched instruction word
//  instr          out  32    registered instruction to decode
//  instr_valid    out  1     instr holds a valid fetched word
//  instr_ready    in   1     decode accepts instr
//  pc             out  XLEN  PC of the instruction in instr
//  pc_plus4       out  XLEN  pc + 4, combinational, drives mux pc_in
//  misalign_trap  out  1     one-cycle pulse (port exists only with MISALIGN_TRAP_EN)
// BEHAVIOUR
//  Reset values (async assert, immediate):
//  - pc=RESET_VECTOR; instr=32'h0000_0013 (NOP); instr_valid=0; imem_req=0; misalign_trap=0; state=BOOT.
//  State machine:
//  - BOOT -> FETCH on the first clock after rst deasserts (imem_req=0 in BOOT).
//  - FETCH: imem_req=1, imem_addr=pc. On imem_ack: instr<=imem_rdata, instr_valid<=1 -> VALID. Ack may arrive in the same cycle as req.
//  - VALID: instr_valid=1, imem_req=0. On instr_ready && !stall: pc<=next_pc, instr_valid<=0 -> FETCH.
//  Latency and throughput:
//  - Minimum 2 cycles per instruction (FETCH with same-cycle ack, then VALID with immediate accept).
//  - imem_rdata to instr: 1 cycle.
//  Stall and ack rules:
//  - stall in FETCH does not drop imem_req; stall only gates the PC update in VALID.
//  - imem_ack outside FETCH is ignored; instr is not overwritten.
//  - instr_ready with instr_valid=0 has no effect.
//  Arithmetic:
//  - pc_plus4 = pc + 4, modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0.
//  - next_pc is sampled only on the accept edge.
//  Reset mid-operation:
//  - Any state returns to BOOT immediately; an in-flight fetch is abandoned.
//  - A late imem_ack is ignored, because BOOT is not FETCH.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//  - On accept with next_pc[1:0]!=0: pc<=TRAP_VECTOR and misalign_trap=1 for exactly that cycle.
//  - Otherwise pc<=next_pc.
//  MISALIGN_TRAP_EN undefined:
//  - misalign_trap port is absent.
//  - pc<={next_pc[XLEN-1:2],2'b00}; low bits are silently cleared.
// STRUCTURE
//  Shared package klp32_pkg:
//  - XLEN, RESET_VECTOR and TRAP_VECTOR defaults.
//  - INSTR_NOP = 32'h0000_0013.
//  - fetch_state_t typedef {BOOT, FETCH, VALID}.
//  Sub-module pc_adder (combinational pc + 4) produces pc_plus4; it is reused by the branch unit.
//  FSM and PC register stay in this module.
// TESTING
//  1. Hold rst for 3 cycles, release:
//     - imem_req=0 in BOOT.
//     - Next cycle imem_req=1, imem_addr=0x0.
//     - pc_plus4=0x4; instr=0x00000013; instr_valid=0.
//  2. Same-cycle ack with imem_rdata=0x00500093, then instr_ready=1 with next_pc=0x4:
//     - Cycle after ack: instr=0x00500093, instr_valid=1.
//     - Cycle after accept: pc=0x4, imem_req=1.
//  3. Ack delayed 3 cycles: imem_req and imem_addr=0x4 remain stable throughout; instr_valid rises one cycle after ack.
//  4. VALID with stall=1 and instr_ready=1 for 4 cycles, next_pc=0x80:
//     - pc holds; instr_valid stays 1.
//     - After stall drops: pc=0x80.
//  5. pc=0xFFFFFFFC: pc_plus4=0x0; accept with next_pc=pc_plus4 gives pc=0x0.
//  6. next_pc=0x102 on accept:
//     - With MISALIGN_TRAP_EN: pc=0x100 and a one-cycle misalign_trap pulse.
//     - Without it: pc=0x100 and no trap port.
//  7. rst asserted mid-FETCH with imem_ack arriving after release:
//     - State=BOOT; pc=RESET_VECTOR.
//     - instr_valid stays 0; the late ack is ignored.

Source files
------------

// File: rtl/klp32_pkg.sv
// klp32_pkg: shared definitions for the klp32 fetch front end.
//   DEFAULT_XLEN          default datapath / address width
//   DEFAULT_RESET_VECTOR  default PC loaded by reset
//   DEFAULT_TRAP_VECTOR   default redirect target for a misaligned next PC
//   INSTR_NOP             canonical NOP (addi x0, x0, 0)
//   fetch_state_t         fetch sequencer states
//   is_misaligned()       true when an address is not word aligned
package klp32_pkg;

  localparam int unsigned DEFAULT_XLEN         = 32;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;
  localparam logic [31:0] INSTR_NOP            = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } fetch_state_t;

  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/pc_adder.sv
// pc_adder: combinational PC + 4, modulo 2^XLEN (all-ones-minus-3 wraps to 0).
// Shared between the fetch sequencer and the branch unit.
//   pc        in   XLEN  current program counter
//   pc_plus4  out  XLEN  pc + 4
module pc_adder
  import klp32_pkg::*;
#(
  parameter int unsigned XLEN = DEFAULT_XLEN
) (
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  always_comb begin
    pc_plus4 = pc + PC_STEP;
  end

endmodule

// File: rtl/pc_fetch_reg.sv
// pc_fetch_reg: architectural PC register and instruction-fetch sequencer.
// Issues one imem fetch per instruction, holds the fetched word for decode
// behind a valid/ready handshake, and advances the PC only on accept.
//
// Build option: define MISALIGN_TRAP_EN to redirect a misaligned next_pc to
// TRAP_VECTOR and expose the misalign_trap pulse; otherwise the two low bits
// of next_pc are cleared and the port does not exist.
//
//   clk            in   1     rising-edge clock
//   rst            in   1     asynchronous, active-high reset
//   next_pc        in   XLEN  next PC from pc_select_mux
//   stall          in   1     hazard hold; blocks PC advance
//   imem_req       out  1     fetch request, held until imem_ack
//   imem_addr      out  XLEN  fetch address (= pc)
//   imem_ack       in   1     imem_rdata valid this cycle
//   imem_rdata     in   32    fetched instruction word
//   instr          out  32    registered instruction to decode
//   instr_valid    out  1     instr holds a valid fetched word
//   instr_ready    in   1     decode accepts instr
//   pc             out  XLEN  PC of the instruction in instr
//   pc_plus4       out  XLEN  pc + 4, drives pc_select_mux pc_in
//   misalign_trap  out  1     one-cycle pulse (MISALIGN_TRAP_EN only)
module pc_fetch_reg
  import klp32_pkg::*;
#(
  parameter int unsigned     XLEN         = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] next_pc,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] pc,
`ifdef MISALIGN_TRAP_EN
  output logic            misalign_trap,
`endif
  output logic [XLEN-1:0] pc_plus4
);

  fetch_state_t    state;
  fetch_state_t    state_nxt;
  logic            fetch_done;
  logic            accept;
  logic [XLEN-1:0] pc_target;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      BOOT:    state_nxt = FETCH;
      FETCH:   if (imem_ack) state_nxt = VALID;
      VALID:   if (instr_ready && !stall) state_nxt = FETCH;
      default: state_nxt = BOOT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM outputs and handshake qualifiers
  // ---------------------------------------------------------------------------
  // instr_valid is decoded from VALID rather than stored separately: the state
  // encodes exactly the same information, so the two can never disagree.
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    fetch_done  = 1'b0;
    accept      = 1'b0;
    unique case (state)
      FETCH: begin
        imem_req   = 1'b1;
        fetch_done = imem_ack;
      end
      VALID: begin
        instr_valid = 1'b1;
        accept      = instr_ready && !stall;
      end
      default: ;
    endcase
  end

  assign imem_addr = pc;

  // ---------------------------------------------------------------------------
  // Redirect target selection
  // ---------------------------------------------------------------------------
`ifdef MISALIGN_TRAP_EN
  logic trap_hit;

  always_comb begin
    trap_hit  = is_misaligned(next_pc[1:0]);
    pc_target = trap_hit ? TRAP_VECTOR : next_pc;
  end
`else
  // TRAP_VECTOR and the low next_pc bits have no function in this build.
  logic unused_trap_cfg;
  assign unused_trap_cfg = ^{TRAP_VECTOR, next_pc[1:0]};

  always_comb begin
    pc_target = {next_pc[XLEN-1:2], 2'b00};
  end
`endif

  // ---------------------------------------------------------------------------
  // PC and instruction registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= RESET_VECTOR;
      instr <= INSTR_NOP;
    end else begin
      if (fetch_done) begin
        instr <= imem_rdata;
      end
      if (accept) begin
        pc <= pc_target;
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  // Registered so it is high only in the cycle that follows the redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_trap <= 1'b0;
    end else begin
      misalign_trap <= accept && trap_hit;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Sequential PC increment
  // ---------------------------------------------------------------------------
  pc_adder #(
    .XLEN (XLEN)
  ) u_pc_adder (
    .pc       (pc),
    .pc_plus4 (pc_plus4)
  );

endmodule

// File: tb/tb_pc_fetch_reg.sv
// tb_pc_fetch_reg: directed scoreboard bench for pc_fetch_reg.
// Stimulus pushes {pc, instr} for every acked fetch; the monitor pops and
// compares whenever decode accepts an instruction.
module tb_pc_fetch_reg;

  logic        clk;
  logic        rst;
  logic [31:0] next_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp;
  int   n_err;
  logic [31:0] exp_pc;

  pc_fetch_reg #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0000),
    .TRAP_VECTOR  (32'h0000_0100)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .next_pc       (next_pc),
    .stall         (stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .pc            (pc),
`ifdef MISALIGN_TRAP_EN
    .misalign_trap (misalign_trap),
`endif
    .pc_plus4      (pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: an accept happens on the next rising edge whenever this holds.
  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready && !stall) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: accept of pc 0x%08h with empty scoreboard", pc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_pc", pc, e.pc);
        check("sb_instr", instr, e.instr);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ack_fetch(input logic [31:0] word);
    exp_t e;
    e.pc    = exp_pc;
    e.instr = word;
    sb_q.push_back(e);
    imem_ack   = 1'b1;
    imem_rdata = word;
    step();
    imem_ack   = 1'b0;
  endtask

  task automatic accept_instr(input logic [31:0] npc, input logic [31:0] new_pc);
    instr_ready = 1'b1;
    next_pc     = npc;
    step();
    instr_ready = 1'b0;
    exp_pc      = new_pc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_pc = 32'h0;
    rst = 1'b1;
    next_pc = '0;
    stall = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = '0;
    instr_ready = 1'b0;

    // 1: reset and boot
    repeat (3) @(posedge clk);
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_valid", {31'b0, instr_valid}, 32'h0);
    check("rst_req", {31'b0, imem_req}, 32'h0);
    rst = 1'b0;
    #1;
    check("boot_req", {31'b0, imem_req}, 32'h0);
    step();
    check("fetch_req", {31'b0, imem_req}, 32'h1);
    check("fetch_addr", imem_addr, 32'h0);
    check("fetch_plus4", pc_plus4, 32'h4);
    check("fetch_instr", instr, 32'h0000_0013);
    check("fetch_valid", {31'b0, instr_valid}, 32'h0);

    // 2: same-cycle ack, immediate accept
    ack_fetch(32'h0050_0093);
    check("t2_instr", instr, 32'h0050_0093);
    check("t2_valid", {31'b0, instr_valid}, 32'h1);
    check("t2_req", {31'b0, imem_req}, 32'h0);
    accept_instr(32'h4, 32'h4);
    check("t2_pc", pc, 32'h4);
    check("t2_req_again", {31'b0, imem_req}, 32'h1);

    // 3: ack delayed by 3 cycles
    for (int i = 0; i < 3; i++) begin
      check("t3_req_hold", {31'b0, imem_req}, 32'h1);
      check("t3_addr_hold", imem_addr, 32'h4);
      check("t3_valid_low", {31'b0, instr_valid}, 32'h0);
      step();
    end
    ack_fetch(32'h00a0_0113);
    check("t3_valid", {31'b0, instr_valid}, 32'h1);

    // 4: stall holds PC in VALID; a stray ack must not overwrite instr
    stall = 1'b1;
    instr_ready = 1'b1;
    next_pc = 32'h80;
    for (int i = 0; i < 4; i++) begin
      imem_ack = (i == 1);
      imem_rdata = 32'hDEAD_BEEF;
      step();
      check("t4_pc_hold", pc, 32'h4);
      check("t4_valid_hold", {31'b0, instr_valid}, 32'h1);
    end
    imem_ack = 1'b0;
    check("t4_instr_kept", instr, 32'h00a0_0113);
    stall = 1'b0;
    step();
    instr_ready = 1'b0;
    exp_pc = 32'h80;
    check("t4_pc", pc, 32'h80);

    // 5: PC wrap at the top of the address space
    ack_fetch(32'h0000_0033);
    accept_instr(32'hFFFF_FFFC, 32'hFFFF_FFFC);
    check("t5_pc_top", pc, 32'hFFFF_FFFC);
    check("t5_plus4_wrap", pc_plus4, 32'h0);
    ack_fetch(32'h0010_0193);
    accept_instr(32'h0, 32'h0);
    check("t5_pc_wrap", pc, 32'h0);

    // 6: misaligned next_pc
    ack_fetch(32'h0020_0213);
    accept_instr(32'h102, 32'h100);
    check("t6_pc", pc, 32'h100);
`ifdef MISALIGN_TRAP_EN
    check("t6_trap_pulse", {31'b0, misalign_trap}, 32'h1);
    step();
    check("t6_trap_clear", {31'b0, misalign_trap}, 32'h0);
`else
    step();
`endif

    // 7: reset mid-FETCH, late ack after release
    check("t7_in_fetch", {31'b0, imem_req}, 32'h1);
    rst = 1'b1;
    #1;
    check("t7_rst_pc", pc, 32'h0);
    check("t7_rst_req", {31'b0, imem_req}, 32'h0);
    check("t7_rst_valid", {31'b0, instr_valid}, 32'h0);
    step();
    rst = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'hBAD0_0BAD;
    #1;
    check("t7_boot_req", {31'b0, imem_req}, 32'h0);
    step();
    imem_ack = 1'b0;
    check("t7_late_valid", {31'b0, instr_valid}, 32'h0);
    check("t7_late_instr", instr, 32'h0000_0013);
    check("t7_late_pc", pc, 32'h0);
    check("t7_fetch_req", {31'b0, imem_req}, 32'h1);

    // normal operation resumes from RESET_VECTOR
    exp_pc = 32'h0;
    ack_fetch(32'h0030_0293);
    accept_instr(32'h4, 32'h4);
    check("t7_resume_pc", pc, 32'h4);
    step();
    check("sb_drain", sb_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
